uart_cmd_decoder: RTL and testbench

- Sits directly downstream of the UART string framing stage, on its receive side.
- Consumes the de-framed payload bytes of one received frame and parses the ASCII command form "K=[-]DDDD".
- Delivers a one-cycle command strobe with key and binary value, or an error strobe with a cause code, to the register/control layer.
- One frame yields exactly one result strobe: either cmd_vld or cmd_err.

---
 rtl/uart_pkg.sv | 38 +++
 rtl/dec_mac10.sv | 26 ++
 rtl/uart_cmd_decoder.sv | 149 ++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART receive-side parsers.
//   - error cause codes reported on err_code
//   - one-hot parser states
//   - ASCII constants and small character-class helpers
package uart_pkg;

  localparam logic [1:0] ERR_KEY    = 2'd0;
  localparam logic [1:0] ERR_SYNTAX = 2'd1;
  localparam logic [1:0] ERR_OVF    = 2'd2;
  localparam logic [1:0] ERR_EMPTY  = 2'd3;

  typedef enum logic [4:0] {
    S_KEY  = 5'b00001,
    S_EQ   = 5'b00010,
    S_SIGN = 5'b00100,
    S_DIG  = 5'b01000,
    S_DROP = 5'b10000
  } state_t;

  localparam logic [7:0] ASC_EQ    = 8'h3D;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_A     = 8'h41;
  localparam logic [7:0] ASC_LA    = 8'h61;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASC_0) && (b <= ASC_0 + 8'd9);
  endfunction

  function automatic logic is_upper(input logic [7:0] b);
    return (b >= ASC_A) && (b <= ASC_A + 8'd25);
  endfunction

  function automatic logic is_lower(input logic [7:0] b);
    return (b >= ASC_LA) && (b <= ASC_LA + 8'd25);
  endfunction

endpackage

// File: rtl/dec_mac10.sv
// Combinational decimal accumulate step: result = acc*10 + digit.
//   acc    : running magnitude (W bits)
//   digit  : decimal digit 0..9
//   limit  : largest magnitude the caller accepts
//   result : low W bits of the new magnitude
//   ovf    : new magnitude does not fit W bits or exceeds limit
module dec_mac10 #(
  parameter int W = 32
) (
  input  logic [W-1:0] acc,
  input  logic [3:0]   digit,
  input  logic [W-1:0] limit,
  output logic [W-1:0] result,
  output logic         ovf
);

  // acc*10 < 16*2^W, so 4 guard bits are enough to see any carry-out.
  logic [W+3:0] prod;

  always_comb begin
    prod   = ({4'd0, acc} << 3) + ({4'd0, acc} << 1) + {{W{1'b0}}, digit};
    result = prod[W-1:0];
    ovf    = (|prod[W+3:W]) || (prod[W-1:0] > limit);
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Parses one de-framed UART payload of the form "K=[-]DDDD" into a key and a
// two's-complement value. Each frame produces exactly one result strobe,
// one cycle after rx_frame_end.
//   rx_byte/rx_byte_vld : payload bytes
//   rx_frame_end        : pulse after the last payload byte (may share its cycle)
//   cmd_key/cmd_value   : decoded command, held until the next cmd_vld
//   cmd_vld / cmd_err   : one-cycle result strobes (mutually exclusive)
//   err_code            : reject cause, held until the next cmd_err
//   busy                : a frame is partially parsed
module uart_cmd_decoder
  import uart_pkg::*;
#(
  parameter int VALUE_WIDTH = 32,
  parameter int MAX_DIGITS  = 10,
  parameter bit ALLOW_NEG   = 1'b1
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic [7:0]             rx_byte,
  input  logic                   rx_byte_vld,
  input  logic                   rx_frame_end,
  output logic [7:0]             cmd_key,
  output logic [VALUE_WIDTH-1:0] cmd_value,
  output logic                   cmd_vld,
  output logic                   cmd_err,
  output logic [1:0]             err_code,
  output logic                   busy
);

  localparam int CW = $clog2(MAX_DIGITS + 2);

  state_t                 state, nxt_state;
  logic [VALUE_WIDTH-1:0] acc, nxt_acc, limit, mac_res, res_val;
  logic [CW-1:0]          cnt, nxt_cnt;
  logic                   neg, nxt_neg, mac_ovf, dig_ok;
  logic [7:0]             key, nxt_key;
  logic [1:0]             drop_code, nxt_code, res_code;
  logic                   res_vld, res_err;

  // Negative numbers may reach one step further than positive ones.
  always_comb begin
    if (!ALLOW_NEG) limit = '1;
    else if (neg)   limit = {1'b1, {(VALUE_WIDTH-1){1'b0}}};
    else            limit = {1'b0, {(VALUE_WIDTH-1){1'b1}}};
  end

  dec_mac10 #(.W(VALUE_WIDTH)) u_mac (
    .acc    (acc),
    .digit  (rx_byte[3:0]),
    .limit  (limit),
    .result (mac_res),
    .ovf    (mac_ovf)
  );

  // A digit is accepted only if it keeps both value and digit count in range.
  assign dig_ok = !mac_ovf && (cnt < CW'(MAX_DIGITS));

  always_comb begin
    nxt_state = state;
    nxt_acc   = acc;
    nxt_cnt   = cnt;
    nxt_neg   = neg;
    nxt_key   = key;
    nxt_code  = drop_code;
    res_vld   = 1'b0;
    res_err   = 1'b0;
    res_code  = ERR_EMPTY;
    res_val   = '0;

    if (rx_byte_vld) begin
      unique case (state)
        S_KEY: begin
          if (is_upper(rx_byte)) begin
            nxt_key = rx_byte; nxt_state = S_EQ;
          end else if (is_lower(rx_byte)) begin
            nxt_key = rx_byte - 8'h20; nxt_state = S_EQ;
          end else begin
            nxt_code = ERR_KEY; nxt_state = S_DROP;
          end
        end
        S_EQ: begin
          if (rx_byte == ASC_EQ) nxt_state = S_SIGN;
          else begin nxt_code = ERR_SYNTAX; nxt_state = S_DROP; end
        end
        S_SIGN, S_DIG: begin
          if (state == S_SIGN && ALLOW_NEG && rx_byte == ASC_MINUS) begin
            nxt_neg = 1'b1; nxt_state = S_DIG;
          end else if (!is_digit(rx_byte)) begin
            nxt_code = ERR_SYNTAX; nxt_state = S_DROP;
          end else if (!dig_ok) begin
            nxt_code = ERR_OVF; nxt_state = S_DROP;
          end else begin
            nxt_acc = mac_res; nxt_cnt = cnt + 1'b1; nxt_state = S_DIG;
          end
        end
        S_DROP: ;
        default: nxt_state = S_DROP;
      endcase
    end

    // Frame end sees the state after any byte arriving in the same cycle.
    if (rx_frame_end) begin
      if (nxt_state == S_DIG && nxt_cnt != '0) begin
        res_vld = 1'b1;
        res_val = nxt_neg ? -nxt_acc : nxt_acc;
      end else begin
        res_err  = 1'b1;
        res_code = (nxt_state == S_DROP) ? nxt_code : ERR_EMPTY;
      end
      nxt_state = S_KEY;
      nxt_acc   = '0;
      nxt_cnt   = '0;
      nxt_neg   = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= S_KEY;
      acc       <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      key       <= '0;
      drop_code <= ERR_KEY;
      cmd_key   <= '0;
      cmd_value <= '0;
      cmd_vld   <= 1'b0;
      cmd_err   <= 1'b0;
      err_code  <= '0;
    end else begin
      state     <= nxt_state;
      acc       <= nxt_acc;
      cnt       <= nxt_cnt;
      neg       <= nxt_neg;
      key       <= nxt_key;
      drop_code <= nxt_code;
      cmd_vld   <= res_vld;
      cmd_err   <= res_err;
      if (res_vld) begin
        cmd_key   <= nxt_key;
        cmd_value <= res_val;
      end
      if (res_err) err_code <= res_code;
    end
  end

  assign busy = (state != S_KEY);

endmodule

// File: tb/tb_uart_cmd_decoder.sv
module tb_uart_cmd_decoder;

  typedef logic [7:0] bq_t[$];

  typedef struct packed {
    logic        vld;
    logic        err;
    logic [7:0]  key;
    logic [31:0] val;
    logic [1:0]  code;
    logic        busy;
  } out_t;

  typedef struct {
    logic [111:0] s;
    bit           fe_same;
    logic [7:0]   key;
    bit           sv;  logic [31:0] sval; logic [1:0] scode;  // ALLOW_NEG=1
    bit           uv;  logic [31:0] uval; logic [1:0] ucode;  // ALLOW_NEG=0
  } vec_t;

  logic        sys_clk, sys_rst_n;
  logic [7:0]  rx_byte;
  logic        rx_byte_vld, rx_frame_end;
  logic [7:0]  cmd_key_s, cmd_key_u;
  logic [31:0] cmd_value_s, cmd_value_u;
  logic        cmd_vld_s, cmd_vld_u, cmd_err_s, cmd_err_u, busy_s, busy_u;
  logic [1:0]  err_code_s, err_code_u;

  uart_cmd_decoder #(.VALUE_WIDTH(32), .MAX_DIGITS(10), .ALLOW_NEG(1'b1)) u_dut_s (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_byte(rx_byte),
    .rx_byte_vld(rx_byte_vld), .rx_frame_end(rx_frame_end),
    .cmd_key(cmd_key_s), .cmd_value(cmd_value_s), .cmd_vld(cmd_vld_s),
    .cmd_err(cmd_err_s), .err_code(err_code_s), .busy(busy_s));

  uart_cmd_decoder #(.VALUE_WIDTH(32), .MAX_DIGITS(10), .ALLOW_NEG(1'b0)) u_dut_u (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_byte(rx_byte),
    .rx_byte_vld(rx_byte_vld), .rx_frame_end(rx_frame_end),
    .cmd_key(cmd_key_u), .cmd_value(cmd_value_u), .cmd_vld(cmd_vld_u),
    .cmd_err(cmd_err_u), .err_code(err_code_u), .busy(busy_u));

  out_t o_s, o_u, hold_s, hold_u;
  assign o_s = {cmd_vld_s, cmd_err_s, cmd_key_s, cmd_value_s, err_code_s, busy_s};
  assign o_u = {cmd_vld_u, cmd_err_u, cmd_key_u, cmd_value_u, err_code_u, busy_u};

  int n_tests = 0, n_fail = 0;
  int strb_s = 0, strb_u = 0, both_cnt = 0, exp_strb = 0;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Independent strobe counter: every frame must give exactly one strobe.
  always @(negedge sys_clk) begin
    if (cmd_vld_s || cmd_err_s) strb_s++;
    if (cmd_vld_u || cmd_err_u) strb_u++;
    if ((cmd_vld_s && cmd_err_s) || (cmd_vld_u && cmd_err_u)) both_cnt++;
  end

  task automatic cmp(input string nm, input out_t got, input out_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got vld=%0b err=%0b key=%h val=%h code=%0d busy=%0b, expected vld=%0b err=%0b key=%h val=%h code=%0d busy=%0b",
               nm, got.vld, got.err, got.key, got.val, got.code, got.busy,
               exp.vld, exp.err, exp.key, exp.val, exp.code, exp.busy);
    end
  endtask

  task automatic cmp_int(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Expected outputs after a frame: strobe plus held fields.
  task automatic expect_dut(input string nm, input out_t got, inout out_t h, input bit v,
                            input logic [7:0] k, input logic [31:0] val, input logic [1:0] c);
    h.vld = v; h.err = !v; h.busy = 1'b0;
    if (v) begin h.key = k; h.val = val; end
    else h.code = c;
    cmp(nm, got, h);
  endtask

  // Reference parser working on the whole string with wide integer arithmetic.
  task automatic model(input bq_t q, input bit an, output bit v, output logic [7:0] key,
                       output logic [31:0] val, output logic [1:0] code);
    longint lim, mag;
    int i, cnt;
    bit neg;
    logic [7:0] k;
    v = 1'b0; key = 8'h00; val = 32'h0; code = 2'd3;
    if (q.size() == 0) return;
    k = q[0];
    if (k >= "a" && k <= "z") k = k - 8'h20;
    else if (!(k >= "A" && k <= "Z")) begin code = 2'd0; return; end
    key = k;
    if (q.size() == 1) return;
    if (q[1] != "=") begin code = 2'd1; return; end
    i = 2; neg = 1'b0;
    if (q.size() > 2 && q[2] == "-") begin
      if (!an) begin code = 2'd1; return; end
      neg = 1'b1; i = 3;
    end
    lim = !an ? 64'hFFFF_FFFF : (neg ? 64'h8000_0000 : 64'h7FFF_FFFF);
    mag = 0; cnt = 0;
    for (; i < q.size(); i++) begin
      if (q[i] < "0" || q[i] > "9") begin code = 2'd1; return; end
      mag = mag * 10 + longint'(q[i] - "0");
      cnt++;
      if (cnt > 10 || mag > lim) begin code = 2'd2; return; end
    end
    if (cnt == 0) return;
    v = 1'b1;
    val = neg ? 32'(-mag) : 32'(mag);
  endtask

  task automatic step(input logic [7:0] b, input bit bv, input bit fe);
    rx_byte = b; rx_byte_vld = bv; rx_frame_end = fe;
    @(posedge sys_clk); #1;
  endtask

  task automatic idle();
    step(8'($urandom_range(0, 255)), 1'b0, 1'b0);
  endtask

  // Drives a frame; returns one cycle after the frame_end cycle with the
  // frame_end inputs still applied, so a next frame can follow with no gap.
  task automatic send_frame(input bq_t q, input bit fe_same, input int gap);
    int n;
    n = q.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat (gap) idle();
      step(q[i], 1'b1, fe_same && (i == n - 1));
    end
    if (!(fe_same && n > 0)) begin
      if (n > 0) repeat (gap) idle();
      step(8'h00, 1'b0, 1'b1);
    end
    exp_strb++;
  endtask

  function automatic bq_t to_q(input logic [111:0] s);
    bq_t q;
    for (int i = 13; i >= 0; i--)
      if (s[8*i +: 8] != 8'h00 || q.size() != 0) q.push_back(s[8*i +: 8]);
    return q;
  endfunction

  localparam int NV = 16;
  vec_t tv[NV];
  logic [79:0] bnd[4];

  initial begin
    bq_t q;
    out_t e;
    bit v_s, v_u;
    logic [7:0] k_s, k_u, b;
    logic [31:0] val_s, val_u;
    logic [1:0] c_s, c_u;
    int nd;
    logic [79:0] bs;

    tv[0]  = '{"F=12345",       0, 8'h46, 1, 32'd12345,    0, 1, 32'd12345,    0};
    tv[1]  = '{"a=-7",          1, 8'h41, 1, 32'hFFFFFFF9, 0, 0, 32'h0,        1};
    tv[2]  = '{"B=4294967296",  0, 8'h42, 0, 32'h0,        2, 0, 32'h0,        2};
    tv[3]  = '{"B=4294967295",  1, 8'h42, 0, 32'h0,        2, 1, 32'hFFFFFFFF, 0};
    tv[4]  = '{"C=-2147483648", 0, 8'h43, 1, 32'h80000000, 0, 0, 32'h0,        1};
    tv[5]  = '{"C=2147483648",  0, 8'h43, 0, 32'h0,        2, 1, 32'h80000000, 0};
    tv[6]  = '{"C=12x4",        1, 8'h43, 0, 32'h0,        1, 0, 32'h0,        1};
    tv[7]  = '{"5=1",           0, 8'h00, 0, 32'h0,        0, 0, 32'h0,        0};
    tv[8]  = '{"D=",            0, 8'h44, 0, 32'h0,        3, 0, 32'h0,        3};
    tv[9]  = '{"",              0, 8'h00, 0, 32'h0,        3, 0, 32'h0,        3};
    tv[10] = '{"E",             0, 8'h45, 0, 32'h0,        3, 0, 32'h0,        3};
    tv[11] = '{"Z=-",           1, 8'h5A, 0, 32'h0,        3, 0, 32'h0,        1};
    tv[12] = '{"z=00000000001", 0, 8'h5A, 0, 32'h0,        2, 0, 32'h0,        2};
    tv[13] = '{"Q=0000000001",  1, 8'h51, 1, 32'd1,        0, 1, 32'd1,        0};
    tv[14] = '{"k=-0",          0, 8'h4B, 1, 32'd0,        0, 0, 32'h0,        1};
    tv[15] = '{"M==",           0, 8'h4D, 0, 32'h0,        1, 0, 32'h0,        1};
    bnd[0] = "2147483647"; bnd[1] = "2147483648";
    bnd[2] = "4294967295"; bnd[3] = "4294967296";

    // Reset state
    sys_rst_n = 1'b0; rx_byte = 8'h00; rx_byte_vld = 1'b0; rx_frame_end = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    hold_s = '0; hold_u = '0;
    cmp("reset_s", o_s, '0);
    cmp("reset_u", o_u, '0);
    sys_rst_n = 1'b1;
    idle();

    // Directed table
    for (int i = 0; i < NV; i++) begin
      q = to_q(tv[i].s);
      send_frame(q, tv[i].fe_same, i % 3);
      expect_dut($sformatf("vec%0d_s", i), o_s, hold_s, tv[i].sv, tv[i].key, tv[i].sval, tv[i].scode);
      expect_dut($sformatf("vec%0d_u", i), o_u, hold_u, tv[i].uv, tv[i].key, tv[i].uval, tv[i].ucode);
      idle();
    end

    // Back-to-back frames with no idle cycle between them
    q = to_q("H=1");
    send_frame(q, 1'b0, 0);
    expect_dut("b2b_h_s", o_s, hold_s, 1'b1, 8'h48, 32'd1, 2'd0);
    expect_dut("b2b_h_u", o_u, hold_u, 1'b1, 8'h48, 32'd1, 2'd0);
    q = to_q("I=2");
    send_frame(q, 1'b0, 0);
    expect_dut("b2b_i_s", o_s, hold_s, 1'b1, 8'h49, 32'd2, 2'd0);
    expect_dut("b2b_i_u", o_u, hold_u, 1'b1, 8'h49, 32'd2, 2'd0);
    idle();

    // Reset in the middle of a frame
    q = to_q("G=12");
    foreach (q[i]) step(q[i], 1'b1, 1'b0);
    idle();
    e = hold_s; e.vld = 0; e.err = 0; e.busy = 1; cmp("busy_mid_s", o_s, e);
    e = hold_u; e.vld = 0; e.err = 0; e.busy = 1; cmp("busy_mid_u", o_u, e);
    sys_rst_n = 1'b0;
    #2;
    hold_s = '0; hold_u = '0;
    cmp("rst_mid_s", o_s, '0);
    cmp("rst_mid_u", o_u, '0);
    idle(); idle();
    sys_rst_n = 1'b1;
    repeat (3) idle();
    cmp("post_rst_s", o_s, '0);
    cmp("post_rst_u", o_u, '0);

    // Randomized frames against the reference parser
    for (int t = 0; t < 300; t++) begin
      q.delete();
      if ($urandom_range(0, 19) != 0) begin
        case ($urandom_range(0, 5))
          0, 1, 2: q.push_back(8'($urandom_range(65, 90)));
          3, 4:    q.push_back(8'($urandom_range(97, 122)));
          default: q.push_back(8'($urandom_range(0, 255)));
        endcase
        if ($urandom_range(0, 15) != 0) q.push_back(($urandom_range(0, 15) == 0) ? 8'h3A : 8'h3D);
        if ($urandom_range(0, 3) == 0) q.push_back(8'h2D);
        if ($urandom_range(0, 3) == 0) begin
          bs = bnd[$urandom_range(0, 3)];
          for (int j = 9; j >= 0; j--) q.push_back(bs[8*j +: 8]);
          if ($urandom_range(0, 1) == 0) q[q.size()-1] = 8'($urandom_range(48, 57));
        end else begin
          nd = $urandom_range(0, 12);
          for (int j = 0; j < nd; j++) q.push_back(8'($urandom_range(48, 57)));
        end
        if ($urandom_range(0, 15) == 0) begin
          b = 8'($urandom_range(0, 255));
          q.insert($urandom_range(0, q.size()), b);
        end
      end
      model(q, 1'b1, v_s, k_s, val_s, c_s);
      model(q, 1'b0, v_u, k_u, val_u, c_u);
      send_frame(q, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      expect_dut($sformatf("rand%0d_s", t), o_s, hold_s, v_s, k_s, val_s, c_s);
      expect_dut($sformatf("rand%0d_u", t), o_u, hold_u, v_u, k_u, val_u, c_u);
      repeat ($urandom_range(0, 2)) idle();
    end

    repeat (3) idle();
    cmp_int("strobe_count_s", strb_s, exp_strb);
    cmp_int("strobe_count_u", strb_u, exp_strb);
    cmp_int("strobes_together", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
